// File: rtl/dual_issue_queue.sv
// Instruction buffer between fetch and the two decode lanes of the 2-way in-order core.
// Issues the oldest one or two entries per cycle, pairing only when lane 1 is independent of lane 0.
module dual_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall,
  input  logic [1:0]    in_valid,
  input  logic [31:0]   in_instr0,
  input  logic [31:0]   in_pc0,
  input  logic [31:0]   in_instr1,
  input  logic [31:0]   in_pc1,
  output logic          in_ready,
  output logic          out_valid0,
  output logic [31:0]   out_instr0,
  output logic [31:0]   out_pc0,
  output logic          out_valid1,
  output logic [31:0]   out_instr1,
  output logic [31:0]   out_pc1,
  output logic [AW:0]   count
);

  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic [31:0]   w_a_instr;
  logic [31:0]   w_b_instr;
  logic [4:0]    w_a_dst;
  logic [4:0]    w_b_dst;
  logic [1:0]    w_b_src;
  logic          w_raw;
  logic          w_waw;
  logic          w_pair_ok;
  logic [1:0]    w_enq_n;
  logic [1:0]    w_deq_n;

  // Destination register; 0 doubles as "no destination" since $0 never creates a hazard.
  function automatic logic [4:0] dst_of(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] rt, input logic [4:0] rd);
    case (op)
      6'h00:   dst_of = (fn == 6'h08) ? 5'd0 : rd;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23:
               dst_of = rt;
      6'h03:   dst_of = 5'd31;
      default: dst_of = 5'd0;
    endcase
  endfunction

  // {reads rs, reads rt}
  function automatic logic [1:0] src_use(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02: src_use = 2'b01;
          6'h08, 6'h09: src_use = 2'b10;
          default:      src_use = 2'b11;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23:
               src_use = 2'b10;
      6'h2B, 6'h04, 6'h05:
               src_use = 2'b11;
      default: src_use = 2'b00;
    endcase
  endfunction

  function automatic logic is_ctrl(input logic [5:0] op, input logic [5:0] fn);
    is_ctrl = (op == 6'h04) || (op == 6'h05) || (op == 6'h02) || (op == 6'h03) ||
              ((op == 6'h00) && ((fn == 6'h08) || (fn == 6'h09)));
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    is_mem = (op == 6'h23) || (op == 6'h2B);
  endfunction

  assign w_head1   = r_head + AW'(1);
  assign w_tail1   = r_tail + AW'(1);
  assign w_a_instr = r_mem_instr[r_head];
  assign w_b_instr = r_mem_instr[w_head1];

  assign w_a_dst = dst_of(w_a_instr[31:26], w_a_instr[5:0], w_a_instr[20:16], w_a_instr[15:11]);
  assign w_b_dst = dst_of(w_b_instr[31:26], w_b_instr[5:0], w_b_instr[20:16], w_b_instr[15:11]);
  assign w_b_src = src_use(w_b_instr[31:26], w_b_instr[5:0]);

  assign w_raw = (w_a_dst != 5'd0) &&
                 ((w_b_src[1] && (w_b_instr[25:21] == w_a_dst)) ||
                  (w_b_src[0] && (w_b_instr[20:16] == w_a_dst)));
  assign w_waw = (w_a_dst != 5'd0) && (w_a_dst == w_b_dst);

  assign w_pair_ok = !is_ctrl(w_a_instr[31:26], w_a_instr[5:0]) && !w_raw && !w_waw &&
                     !(is_mem(w_a_instr[31:26]) && is_mem(w_b_instr[31:26]));

  assign in_ready   = (r_count <= READY_MAX);
  assign out_valid0 = (r_count >= (AW+1)'(1)) && !stall && !flush;
  assign out_valid1 = (r_count >= (AW+1)'(2)) && !stall && !flush && w_pair_ok;
  assign out_instr0 = w_a_instr;
  assign out_pc0    = r_mem_pc[r_head];
  assign out_instr1 = w_b_instr;
  assign out_pc1    = r_mem_pc[w_head1];
  assign count      = r_count;

  // The illegal slot pattern 10 enqueues nothing.
  always_comb begin
    w_enq_n = 2'd0;
    if (in_ready && !flush) begin
      case (in_valid)
        2'b01:   w_enq_n = 2'd1;
        2'b11:   w_enq_n = 2'd2;
        default: w_enq_n = 2'd0;
      endcase
    end
  end

  assign w_deq_n = {1'b0, out_valid0} + {1'b0, out_valid1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_n);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + (AW+1)'(w_enq_n) - (AW+1)'(w_deq_n);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (w_enq_n != 2'd0) begin
      r_mem_instr[r_tail] <= in_instr0;
      r_mem_pc[r_tail]    <= in_pc0;
    end
    if (w_enq_n == 2'd2) begin
      r_mem_instr[w_tail1] <= in_instr1;
      r_mem_pc[w_tail1]    <= in_pc1;
    end
  end

endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Instruction buffer between fetch and the two decode/controller lanes of the 2-way in-order core.
- Accepts instruction pairs from fetch and hands the oldest one or two instructions to decode lanes 0 and 1 each cycle.
- Applies the pairing rules in program order, so the lane-1 instruction never depends on or conflicts with lane 0.
- Supplies the opcode/func stream that the controllers consume.

Parameters:
- DEPTH, 8: entry count; power of two, at least 4.
- AW, 3: pointer width, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  discard all queued entries (taken jump/branch).
- stall  in  1  decode cannot accept; nothing issues this cycle.
- in_valid  in  2  fetch slots valid; legal values 00, 01, 11.
- in_instr0  in  32  older fetched instruction.
- in_pc0  in  32  PC of in_instr0.
- in_instr1  in  32  younger fetched instruction.
- in_pc1  in  32  PC of in_instr1.
- in_ready  out  1  queue can take a full pair.
- out_valid0  out  1  lane 0 issues this cycle.
- out_instr0  out  32  lane 0 instruction.
- out_pc0  out  32  lane 0 PC.
- out_valid1  out  1  lane 1 issues this cycle.
- out_instr1  out  32  lane 1 instruction.
- out_pc1  out  32  lane 1 PC.
- count  out  AW+1  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous): head=0, tail=0, count=0. Consequently in_ready=1 and out_valid0=out_valid1=0. Entry contents are don't-care.
- in_ready = (DEPTH - count >= 2). It is computed from registered count only, with no dependence on same-cycle dequeue.
- Enqueue on a clock edge when in_ready=1 and flush=0:
  - in_valid=01 writes slot 0 at tail; tail+1.
  - in_valid=11 writes slots 0 and 1 at tail and tail+1; tail+2.
  - in_valid=10 is illegal and is ignored (no write).
- Pointers wrap modulo DEPTH.
- Issue (combinational from the head entries):
  - Entry A = mem[head], entry B = mem[head+1].
  - out_valid0 = (count>=1) && !stall && !flush.
  - out_valid1 = (count>=2) && !stall && !flush && pair_ok.
  - out_instr/out_pc are driven from A/B even when the corresponding valid is 0.
- Dequeue at the clock edge: head += out_valid0 + out_valid1.
- Occupancy: count_next = count + enq_n − deq_n. Enqueued entries become issuable the next cycle at the earliest (no bypass).
- Register decode used for pairing (instr fields rs=[25:21], rt=[20:16], rd=[15:11]):
  - Destination: rd for R-type except jr (none). jalr writes rd. rt for addi/addiu/andi/ori/slti/sltiu/xori/lui/lw. $31 for jal. None for sw/beq/bne/j. Unknown opcodes have no destination.
  - Sources: rs,rt for R-type except sll/srl (rt only), jr (rs), jalr (rs). rs for I-type ALU ops and lw. rs,rt for sw/beq/bne. None for lui/j/jal.
- pair_ok is 0 if any of the following holds:
  - A is a control transfer (beq, bne, j, jal, jr, jalr).
  - A has a destination d != 0 and B sources d (RAW).
  - A and B both have the same destination d != 0 (WAW).
  - A and B are both memory ops (lw/sw).
  - Otherwise pair_ok = 1. A control transfer in lane 1 is allowed.
- Flush has priority over everything at the clock edge: head=tail=0, count=0, no enqueue. Same-cycle fetch data is dropped.
- Full: with count=DEPTH−1 or DEPTH, in_ready=0. Fetch must hold its data.
- Empty: out_valid0=out_valid1=0 regardless of stall.
- Stall and enqueue in the same cycle: enqueue proceeds, no dequeue.

Test Plan:
1. Reset then fetch pair {0x00221820 add $3,$1,$2 ; 0x20070001 addi $7,$0,1}, stall=0 → cycle+1: count=2, out_valid0=1, out_valid1=1, pcs issue in order; cycle+2: count=0.
2. RAW: pair {0x00221820 ; 0x20640005 addi $4,$3,5} → first cycle only out_valid0=1 (add); next cycle addi issues alone in lane 0.
3. Dest $0 and memory: {0x20200001 addi $0,$1,1 ; 0x00021820} → dual issue (no RAW on $0). {0x8C050000 lw ; 0xAC060004 sw} → single issue twice.
4. Branch in lane 0: {0x10220003 beq ; 0x00221820} → beq issues alone. Then flush=1 with in_valid=11 the same cycle → count=0, both valids 0 next cycle, fetched pair discarded.
5. Fill/wrap: hold stall=1, push 4 pairs → count=8, in_ready=0 from count=7 onward. Release stall with independent pairs → drain 2/cycle, head wraps 7→0 with PCs in order.
6. Assert rst low mid-stream with count=5, stall=0 → immediately count=0, out_valid0/1=0, in_ready=1, with no edge required.
